wide_add_sequencer: RTL

- Multi-cycle wide-operand adder front end that sits directly upstream of, and instantiates, one `ADDER_SIZE`-bit brent_kung_adder.
- Accepts a WORDS×`ADDER_SIZE`-bit operand pair over a valid/ready handshake.
- Feeds the adder one word per cycle, LSW first, chaining the registered carry between words.
- Returns the full-width sum and final carry over a second valid/ready handshake.

---
 rtl/wide_add_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/wide_add_sequencer.sv
// Word-serial wide adder: streams WORDS chunks LSW-first through one Brent-Kung adder, chaining carry.
// Optional WIDE_ADD_SUB_EN macro adds an in_sub port for A-B (B inverted, carry seeded with 1).
`ifndef ADDER_SIZE
`define ADDER_SIZE 32
`endif

module brent_kung_adder (
  input  logic [`ADDER_SIZE-1:0] a,
  input  logic [`ADDER_SIZE-1:0] b,
  input  logic                   cin,
  output logic [`ADDER_SIZE-1:0] sum,
  output logic                   cout
);
  localparam int N  = `ADDER_SIZE;
  localparam int LV = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] prop;
  logic [N-1:0] gg;
  logic [N-1:0] pp;
  logic [N:0]   carry;

  assign prop = a ^ b;

  // In-place prefix tree: up-sweep builds power-of-two spans, down-sweep fills the gaps.
  always_comb begin
    gg = a & b;
    pp = prop;
    gg[0] = (a[0] & b[0]) | (prop[0] & cin);
    for (int lv = 0; lv < LV; lv++) begin
      for (int i = 0; i < N; i++) begin
        if ((((i + 1) % (1 << (lv + 1))) == 0) && (i >= (1 << lv))) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << lv)]);
          pp[i] = pp[i] & pp[i - (1 << lv)];
        end
      end
    end
    for (int lv = LV - 2; lv >= 0; lv--) begin
      for (int i = 0; i < N; i++) begin
        if ((((i + 1) % (1 << (lv + 1))) == (1 << lv)) &&
            (i >= ((1 << (lv + 1)) + (1 << lv) - 1))) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << lv)]);
          pp[i] = pp[i] & pp[i - (1 << lv)];
        end
      end
    end
  end

  assign carry = {gg, cin};
  assign sum   = prop ^ carry[N-1:0];
  assign cout  = carry[N];
endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WORDS*`ADDER_SIZE-1:0]   in_op1,
  input  logic [WORDS*`ADDER_SIZE-1:0]   in_op2,
  input  logic                           in_cin,
`ifdef WIDE_ADD_SUB_EN
  input  logic                           in_sub,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WORDS*`ADDER_SIZE-1:0]   out_res,
  output logic                           out_cout
);
  localparam int AS = `ADDER_SIZE;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [IW-1:0]            idx;
  logic                     carry;
  logic [WORDS-1:0][AS-1:0] op_a;
  logic [WORDS-1:0][AS-1:0] op_b;
  logic [WORDS-1:0][AS-1:0] res;
  logic [AS-1:0]            sum_w;
  logic                     cout_w;
  logic [WORDS*AS-1:0]      op_b_load;
  logic                     carry_load;

`ifdef WIDE_ADD_SUB_EN
  assign op_b_load  = in_sub ? ~in_op2 : in_op2;
  assign carry_load = in_sub ? 1'b1 : in_cin;
`else
  assign op_b_load  = in_op2;
  assign carry_load = in_cin;
`endif

  assign in_ready = (state == IDLE);
  assign out_res  = res;

  brent_kung_adder u_adder (
    .a    (op_a[idx]),
    .b    (op_b[idx]),
    .cin  (carry),
    .sum  (sum_w),
    .cout (cout_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= in_op1;
            op_b  <= op_b_load;
            carry <= carry_load;
            idx   <= '0;
            res   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res[idx] <= sum_w;
          carry    <= cout_w;
          if (idx == IW'(WORDS - 1)) begin
            out_cout  <= cout_w;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
